// File: rtl/bwt_pkg.sv
// Shared constants, FSM state type and index helper for the BWT stream engine.
package bwt_pkg;

  localparam int BWT_CHAR_W  = 8;
  localparam int BWT_MAX_LEN = 64;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    EMIT = 2'd2
  } bwt_state_e;

  // Predecessor of a rotation start index, wrapping from 0 back to len-1.
  function automatic logic [15:0] wrap_dec(input logic [15:0] idx, input logic [15:0] len);
    return (idx == 16'd0) ? (len - 16'd1) : (idx - 16'd1);
  endfunction

endpackage

// File: rtl/bwt_rot_sort.sv
// Rotation sorter: insertion sort of rotation start indices, with a sequential
// one-character-per-cycle rotation comparator. Equal rotations keep ascending
// start-index order.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | waiting for start; sa holds last result
//   S_PICK  | choose compare partner for key, or drop key in
//   S_CMP   | walk both rotations until they differ or wrap
module bwt_rot_sort
  import bwt_pkg::*;
#(
  parameter int CHAR_W  = BWT_CHAR_W,
  parameter int MAX_LEN = BWT_MAX_LEN,
  localparam int IDX_W  = $clog2(MAX_LEN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IDX_W:0]            len,
  input  logic [MAX_LEN*CHAR_W-1:0] blk_buf,
  output logic [MAX_LEN*IDX_W-1:0]  sa,
  output logic                      done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PICK = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;

  logic [MAX_LEN-1:0][CHAR_W-1:0] bb;
  logic [MAX_LEN-1:0][IDX_W-1:0]  sa_q, sa_d;
  logic [1:0]       st_q, st_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [IDX_W-1:0] i_q, i_d, pos_q, pos_d, key_q, key_d;
  logic [IDX_W-1:0] pa_q, pa_d, pb_q, pb_d, cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] last_idx;
  logic [CHAR_W-1:0] ca, cb;

  assign bb       = blk_buf;
  assign sa       = sa_q;
  assign done     = done_q;
  assign last_idx = IDX_W'(len_q - 1'b1);
  assign ca       = bb[pa_q];
  assign cb       = bb[pb_q];

  // Sort sequencing: shift larger entries right until key finds its slot.
  always_comb begin
    logic adv, settle, greater;
    sa_d    = sa_q;
    st_d    = st_q;
    len_d   = len_q;
    i_d     = i_q;
    pos_d   = pos_q;
    key_d   = key_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    settle  = 1'b0;
    greater = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < MAX_LEN; k++) sa_d[k] = IDX_W'(k);
          len_d = len;
          if (len <= (IDX_W+1)'(1)) begin
            done_d = 1'b1;
          end else begin
            i_d   = IDX_W'(1);
            key_d = IDX_W'(1);
            pos_d = IDX_W'(1);
            st_d  = S_PICK;
          end
        end
      end
      S_PICK: begin
        if (pos_q == '0) begin
          sa_d[0] = key_q;
          adv     = 1'b1;
        end else begin
          pa_d  = sa_q[pos_q - 1'b1];
          pb_d  = key_q;
          cnt_d = '0;
          st_d  = S_CMP;
        end
      end
      S_CMP: begin
        if (ca != cb) begin
          settle  = 1'b1;
          greater = (ca > cb);
        end else if (cnt_q == last_idx) begin
          settle  = 1'b1;
          greater = (sa_q[pos_q - 1'b1] > key_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
          pa_d  = (pa_q == last_idx) ? '0 : pa_q + 1'b1;
          pb_d  = (pb_q == last_idx) ? '0 : pb_q + 1'b1;
        end
        if (settle) begin
          if (greater) begin
            sa_d[pos_q] = sa_q[pos_q - 1'b1];
            pos_d       = pos_q - 1'b1;
            st_d        = S_PICK;
          end else begin
            sa_d[pos_q] = key_q;
            adv         = 1'b1;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
    if (adv) begin
      if (i_q == last_idx) begin
        done_d = 1'b1;
        st_d   = S_IDLE;
      end else begin
        i_d   = i_q + 1'b1;
        key_d = sa_q[i_q + 1'b1];
        pos_d = i_q + 1'b1;
        st_d  = S_PICK;
      end
    end
  end

  // Sorter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q   <= '0;
      st_q   <= S_IDLE;
      len_q  <= '0;
      i_q    <= '0;
      pos_q  <= '0;
      key_q  <= '0;
      pa_q   <= '0;
      pb_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sa_q   <= sa_d;
      st_q   <= st_d;
      len_q  <= len_d;
      i_q    <= i_d;
      pos_q  <= pos_d;
      key_q  <= key_d;
      pa_q   <= pa_d;
      pb_q   <= pb_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/bwt_stream_engine.sv
// Streaming Burrows-Wheeler transform engine: LOAD a block, SORT its
// rotations, EMIT the last column and the primary index.
// Optional macro BWT_PIDX_EN: when defined, primary-index tracking drives
// m_pidx; otherwise m_pidx is tied to 0.
//
//   state | meaning
//   ------+--------------------------------------------
//   LOAD  | accepting input beats into the block buffer
//   SORT  | rotation sorter running
//   EMIT  | streaming last-column characters out
module bwt_stream_engine
  import bwt_pkg::*;
#(
  parameter int CHAR_W  = BWT_CHAR_W,
  parameter int MAX_LEN = BWT_MAX_LEN,
  localparam int IDX_W  = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHAR_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [CHAR_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  output logic [IDX_W-1:0]  m_pidx,
  input  logic              m_ready,
  output logic              busy
);

  bwt_state_e state_q, state_d;
  logic [MAX_LEN-1:0][CHAR_W-1:0] mem_q, mem_d;
  logic [IDX_W-1:0]  wr_q, wr_d, iss_q, iss_d;
  logic [IDX_W:0]    len_q, len_d;
  logic              iss_done_q, iss_done_d;
  logic              start_q, start_d;
  logic              s_ready_q, s_ready_d;
  logic [CHAR_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
`ifdef BWT_PIDX_EN
  logic [IDX_W-1:0]  m_pidx_q, m_pidx_d, pidx_cap_q, pidx_cap_d;
`endif

  logic                          srt_done;
  logic [MAX_LEN*IDX_W-1:0]      sa_flat;
  logic [MAX_LEN-1:0][IDX_W-1:0] sa_arr;
  logic [IDX_W-1:0]              sa_k, beat_src;
  logic                          beat_last;

  bwt_rot_sort #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN)) u_sort (
    .clk     (clk),
    .rst     (rst),
    .start   (start_q),
    .len     (len_q),
    .blk_buf (mem_q),
    .sa      (sa_flat),
    .done    (srt_done)
  );

  assign sa_arr    = sa_flat;
  assign sa_k      = sa_arr[iss_q];
  assign beat_src  = IDX_W'(wrap_dec(16'(sa_k), 16'(len_q)));
  assign beat_last = (iss_q == IDX_W'(len_q - 1'b1));

  assign s_ready = s_ready_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q == SORT) || (state_q == EMIT);
`ifdef BWT_PIDX_EN
  assign m_pidx  = m_pidx_q;
`else
  assign m_pidx  = '0;
`endif

  // Block FSM, buffer write, and output register loading.
  always_comb begin
    logic issue;
    state_d    = state_q;
    mem_d      = mem_q;
    wr_d       = wr_q;
    len_d      = len_q;
    iss_d      = iss_q;
    iss_done_d = iss_done_q;
    start_d    = 1'b0;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
`ifdef BWT_PIDX_EN
    m_pidx_d   = m_pidx_q;
    pidx_cap_d = pidx_cap_q;
`endif
    issue = 1'b0;
    case (state_q)
      LOAD: begin
        if (s_valid && s_ready_q) begin
          mem_d[wr_q] = s_data;
          if (s_last || (wr_q == IDX_W'(MAX_LEN - 1))) begin
            len_d      = {1'b0, wr_q} + 1'b1;
            wr_d       = '0;
            iss_d      = '0;
            iss_done_d = 1'b0;
            start_d    = 1'b1;
            state_d    = SORT;
          end else begin
            wr_d = wr_q + 1'b1;
          end
        end
      end
      SORT: begin
        // Beat 0 is loaded on the done cycle so m_valid follows immediately.
        if (srt_done) begin
          issue   = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (!m_valid_q || m_ready) begin
          if (!iss_done_q) begin
            issue = 1'b1;
          end else begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    if (issue) begin
      m_valid_d  = 1'b1;
      m_data_d   = mem_q[beat_src];
      m_last_d   = beat_last;
      iss_d      = iss_q + 1'b1;
      iss_done_d = beat_last;
`ifdef BWT_PIDX_EN
      if (sa_k == '0) pidx_cap_d = iss_q;
      m_pidx_d = beat_last ? ((sa_k == '0) ? iss_q : pidx_cap_q) : '0;
`endif
    end
    s_ready_d = (state_d == LOAD);
  end

  // Control and output registers; abort to idle on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      wr_q       <= '0;
      len_q      <= '0;
      iss_q      <= '0;
      iss_done_q <= 1'b0;
      start_q    <= 1'b0;
      s_ready_q  <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
`ifdef BWT_PIDX_EN
      m_pidx_q   <= '0;
      pidx_cap_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      len_q      <= len_d;
      iss_q      <= iss_d;
      iss_done_q <= iss_done_d;
      start_q    <= start_d;
      s_ready_q  <= s_ready_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
`ifdef BWT_PIDX_EN
      m_pidx_q   <= m_pidx_d;
      pidx_cap_q <= pidx_cap_d;
`endif
    end
  end

  // Block buffer; contents survive reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
